contador_m_modos: RTL and testbench

- Parametrised successor to the modulo-M counter family: one N-bit modulo-M counter with runtime mode selection.
- Modes cover up/down counting, saturate ("trava") versus wrap-around, and synchronous parallel load.
- Provides level flags (fim, inicio, meio, limiar) and event outputs (estouro pulse, sticky travado).
- Serves the datapath wherever counters for timeouts, addresses or round counts are needed, including ones that must hold at a boundary.

---
 rtl/contador_m_modos.sv | 123 ++++++++++++
 tb/tb_contador_m_modos.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/contador_m_modos.sv
// contador_m_modos: N-bit modulo-M counter with runtime mode selection.
// Supports up/down counting, saturation versus wrap-around at the range
// boundaries, and a clamped synchronous parallel load. Level flags are decoded
// from the registered count. estouro is a one-cycle boundary pulse, and
// travado is a sticky flag for a blocked saturated count.
module contador_m_modos #(
    parameter int M      = 100,
    parameter int N      = 7,
    parameter int LIMIAR = 50
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] D,
    input  logic         conta,
    input  logic         desce,
    input  logic         trava,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         inicio,
    output logic         meio,
    output logic         limiar,
    output logic         estouro,
    output logic         travado
);

    // Decode constants, sized to the counter width.
    localparam logic [N-1:0] Q_MAX  = N'(M - 1);
    localparam logic [N-1:0] Q_MEIO = N'(M / 2 - 1);
    localparam logic [N-1:0] Q_LIM  = N'(LIMIAR);
    localparam logic [N-1:0] Q_ZERO = {N{1'b0}};
    localparam logic [N-1:0] Q_UM   = {{(N-1){1'b0}}, 1'b1};

    // Flag an elaboration error when the modulus does not fit in N bits.
    if ((64'd1 << N) < 64'(M)) begin : g_largura_invalida
        $error("contador_m_modos: 2**N must be >= M");
    end

    logic [N-1:0] q_r;
    logic         estouro_r;
    logic         travado_r;
    logic [N-1:0] q_next_s;
    logic         estouro_next_s;
    logic         travado_next_s;

    // Next-state selection with priority zera_s > carrega > conta.
    always_comb begin
        q_next_s       = q_r;
        estouro_next_s = 1'b0;
        travado_next_s = travado_r;
        if (zera_s) begin
            q_next_s       = Q_ZERO;
            travado_next_s = 1'b0;
        end else if (carrega) begin
            // Out-of-range load values clamp to the top of the range.
            if (D > Q_MAX) begin
                q_next_s = Q_MAX;
            end else begin
                q_next_s = D;
            end
            travado_next_s = 1'b0;
        end else if (conta) begin
            if (!desce) begin
                // Up: the >= compare also pulls an illegal Q back into range.
                if (q_r >= Q_MAX) begin
                    estouro_next_s = 1'b1;
                    if (trava) begin
                        q_next_s       = Q_MAX;
                        travado_next_s = 1'b1;
                    end else begin
                        q_next_s = Q_ZERO;
                    end
                end else begin
                    q_next_s = q_r + Q_UM;
                end
            end else begin
                // Down: the boundary is Q == 0. An illegal Q returns to the top.
                if (q_r == Q_ZERO) begin
                    estouro_next_s = 1'b1;
                    if (trava) begin
                        q_next_s       = Q_ZERO;
                        travado_next_s = 1'b1;
                    end else begin
                        q_next_s = Q_MAX;
                    end
                end else if (q_r > Q_MAX) begin
                    q_next_s = Q_MAX;
                end else begin
                    q_next_s = q_r - Q_UM;
                end
            end
        end else begin
            q_next_s       = q_r;
            estouro_next_s = 1'b0;
        end
    end

    // State register with synchronous active-high clear.
    always_ff @(posedge clock) begin
        if (zera_s) begin
            q_r       <= Q_ZERO;
            estouro_r <= 1'b0;
            travado_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            estouro_r <= estouro_next_s;
            travado_r <= travado_next_s;
        end
    end

    // Level flags are zero-latency decodes of the registered count.
    always_comb begin
        fim    = (q_r == Q_MAX);
        inicio = (q_r == Q_ZERO);
        meio   = (q_r == Q_MEIO);
        limiar = (q_r >= Q_LIM);
    end

    assign Q       = q_r;
    assign estouro = estouro_r;
    assign travado = travado_r;

endmodule

// File: tb/tb_contador_m_modos.sv
// Scoreboard bench for contador_m_modos (M=10, N=4, LIMIAR=7).
// The driver pushes the reference model's expected state after each edge, and
// the monitor pops one entry per edge and compares it with the DUT outputs.
module tb_contador_m_modos;

    localparam int M      = 10;
    localparam int N      = 4;
    localparam int LIMIAR = 7;

    logic         clock = 1'b0;
    logic         zera_s = 1'b0;
    logic         carrega = 1'b0;
    logic [N-1:0] D = '0;
    logic         conta = 1'b0;
    logic         desce = 1'b0;
    logic         trava = 1'b0;
    logic [N-1:0] Q;
    logic         fim, inicio, meio, limiar, estouro, travado;

    contador_m_modos #(.M(M), .N(N), .LIMIAR(LIMIAR)) dut (
        .clock(clock), .zera_s(zera_s), .carrega(carrega), .D(D),
        .conta(conta), .desce(desce), .trava(trava), .Q(Q),
        .fim(fim), .inicio(inicio), .meio(meio), .limiar(limiar),
        .estouro(estouro), .travado(travado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int q;
        int est;
        int trv;
        string tag;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_q   = 0;
    int m_est = 0;
    int m_trv = 0;

    task automatic chk(input string nm, input string tag, input logic [7:0] act,
                       input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s [%s]: got %0d required %0d", nm, tag, act, req);
        end
    endtask

    // One stimulus cycle: drive the inputs, advance the model, and push the expectation.
    task automatic step(input string tag, input bit z, input bit ld, input int d,
                        input bit en, input bit dn, input bit tv);
        exp_t e;
        @(negedge clock);
        zera_s = z; carrega = ld; D = N'(d); conta = en; desce = dn; trava = tv;
        if (z) begin
            m_q = 0; m_est = 0; m_trv = 0;
        end else if (ld) begin
            m_q = (d > M - 1) ? M - 1 : d;
            m_est = 0; m_trv = 0;
        end else if (en) begin
            m_est = 0;
            if (!dn) begin
                if (m_q == M - 1) begin
                    m_est = 1;
                    if (tv) m_trv = 1; else m_q = 0;
                end else m_q = m_q + 1;
            end else begin
                if (m_q == 0) begin
                    m_est = 1;
                    if (tv) m_trv = 1; else m_q = M - 1;
                end else m_q = m_q - 1;
            end
        end else begin
            m_est = 0;
        end
        e.q = m_q; e.est = m_est; e.trv = m_trv; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the DUT with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("Q", e.tag, 8'(Q), 8'(e.q));
                chk("estouro", e.tag, 8'(estouro), 8'(e.est));
                chk("travado", e.tag, 8'(travado), 8'(e.trv));
                chk("fim", e.tag, 8'(fim), 8'(e.q == M - 1));
                chk("inicio", e.tag, 8'(inicio), 8'(e.q == 0));
                chk("meio", e.tag, 8'(meio), 8'(e.q == M / 2 - 1));
                chk("limiar", e.tag, 8'(limiar), 8'(e.q >= LIMIAR));
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        int guard;
        step("reset", 1, 1, 5, 1, 0, 0);
        for (int i = 0; i < 12; i++) step("up_wrap", 0, 0, 0, 1, 0, 0);
        step("load8", 0, 1, 8, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("up_sat", 0, 0, 0, 1, 0, 1);
        step("load1", 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("down_wrap", 0, 0, 0, 1, 1, 0);
        step("load13", 0, 1, 13, 0, 0, 0);
        step("load_vs_count", 0, 1, 13, 1, 0, 0);
        step("load0", 0, 1, 0, 0, 1, 1);
        step("down_sat", 0, 0, 0, 1, 1, 1);
        step("down_sat2", 0, 0, 0, 1, 1, 1);
        step("idle", 0, 0, 0, 0, 1, 1);
        step("zera_vs_load", 1, 1, 5, 1, 1, 1);
        step("load9", 0, 1, 9, 0, 0, 1);
        step("hold9", 0, 0, 0, 1, 0, 1);
        step("unlock_wrap", 0, 0, 0, 1, 0, 0);
        step("after_wrap", 0, 0, 0, 1, 0, 0);
        step("reload", 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end
        @(negedge clock);
        conta = 1'b0; carrega = 1'b0; zera_s = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
